jtag_shift_master: RTL and testbench
====================================

Name: jtag_shift_master

Overview:
- Synthesizable JTAG initiator: drives the TCK/TMS/TDI pins of the SoC's debug TAP and captures TDO.
- Used in the SoC bench, and in FPGA bring-up, to issue IR/DR scans without an external probe. Nothing ties jtag_* off any more.
- Host side is a valid/ready command port plus a one-shot response. The block walks the TAP state machine and always returns the TAP to Run-Test/Idle.

Parameters:
- TCK_DIV, 4: TCK half-period in clk cycles; must be ≥2.
- MAX_LEN, 64: maximum shift length in bits; also the width of the data buses.
- LEN_W, 7: width of cmd_len; must be ≥ clog2(MAX_LEN+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block is idle and accepts a command.
- cmd_op  in  2  00 RESET, 01 SCAN_IR, 10 SCAN_DR, 11 IDLE_CYC.
- cmd_len  in  LEN_W  bits to shift (IR/DR) or TCK cycles to run (IDLE_CYC).
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  one-cycle pulse when the command completes.
- rsp_err  out  1  valid with rsp_valid; bad length.
- rsp_data  out  MAX_LEN  captured TDO bits; first bit at [0]; bits ≥ len are 0.
- jtag_tck  out  1  test clock.
- jtag_tms  out  1  test mode select.
- jtag_tdi  out  1  test data in.
- jtag_tdo  in  1  test data out from the TAP.

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, jtag_tck=0, jtag_tms=1, jtag_tdi=0. Internal TAP position is assumed unknown until a RESET command is issued.
- Handshake: a command is accepted on a cycle with cmd_valid && cmd_ready. All fields are registered on acceptance. cmd_ready drops the next cycle and rises again in the cycle after the rsp_valid pulse. Inputs are ignored while busy.
- TCK generation:
  - A divide counter runs only while busy.
  - Each TCK period is TCK_DIV clk cycles low, then TCK_DIV cycles high.
  - TMS and TDI change only at the falling edge (start of the low phase).
  - TDO is sampled in the clk cycle where TCK rises.
  - jtag_tck is a register output and idles low.
- FSM states: IDLE, PRE, SHIFT, POST, DONE.
  - RESET: PRE drives TMS=1,1,1,1,1,0 (6 TCK periods), then DONE.
  - SCAN_IR: PRE drives TMS=1,1,0,0, then SHIFT, then POST drives TMS=1,0. Total TCK periods = 6+len.
  - SCAN_DR: PRE drives TMS=1,0,0, then SHIFT, then POST drives TMS=1,0. Total TCK periods = 5+len.
  - SHIFT: exactly len TCK periods. TDI=cmd_data[i] in period i. TMS=0 except TMS=1 in the last period (i=len-1). TDO sampled in period i is written to rsp_data[i].
  - IDLE_CYC: SHIFT with TMS=0 and TDI=0 for len periods. No capture; rsp_data=0.
  - DONE: one clk cycle after the final TCK falling edge. Pulses rsp_valid, then returns to IDLE.
- Error case: len==0 or len>MAX_LEN for SCAN_IR, SCAN_DR or IDLE_CYC.
  - No TCK activity.
  - DONE is entered on the cycle after acceptance, with rsp_err=1 and rsp_data=0.
  - RESET ignores len.
- rsp_data and rsp_err hold their value until the next command completes.
- Reset mid-operation: all outputs return to their reset values immediately and any capture in progress is discarded. The host must issue RESET before the next scan.

Decomposition:
- Shared package jtag_pkg holds the op encodings, FSM state encodings, and the PRE/POST TMS patterns with their lengths.
- One sub-module, jtag_tck_gen: divide counter producing tck, fall_strobe and rise_strobe, with an enable input.

Test Plan:
- RESET, TCK_DIV=4 → exactly 6 TCK rising edges of period 8 clk; TMS=1 on the first 5 and 0 on the 6th; rsp_valid after ~48 clk; TAP model in RTI.
- SCAN_IR, len=5, data=5'h01 → TAP model IR=0x01; rsp_data[4:0]=0x01 (capture pattern); 11 TCK periods; model ends in RTI.
- SCAN_DR, len=32, data=0, after IR=IDCODE → rsp_data[31:0] equals the model IDCODE (e.g. 0x1E200A6D); rsp_data[63:32]=0.
- SCAN_DR, len=64, data=64'hA5A5_0000_FFFF_1234 through a 64-bit bypass-chain model → rsp_data equals the same value (model delay compensated); last-bit TMS=1.
- SCAN_DR with len=0, and with len=65 (LEN_W=7) → rsp_err=1 one cycle after acceptance; jtag_tck never toggles.
- Assert rst_n low mid-SHIFT → jtag_tck=0, jtag_tms=1, cmd_ready=1 at once; a subsequent RESET then IR scan completes correctly.

Source files
------------

// File: rtl/jtag_pkg.sv
// ---------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the JTAG shift master:
//   op_t      host command encodings (RESET / SCAN_IR / SCAN_DR / IDLE_CYC)
//   state_t   sequencer states, also exported on the debug port
//   TMS walk patterns for the PRE and POST phases, stored LSB-first
//   (bit k is the TMS value for TCK period k of that phase).
// ---------------------------------------------------------------------------
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'b00,
    OP_SCAN_IR  = 2'b01,
    OP_SCAN_DR  = 2'b10,
    OP_IDLE_CYC = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Any state -> Test-Logic-Reset (five 1s) -> Run-Test/Idle.
  localparam logic [7:0] TMS_PRE_RESET = 8'b0001_1111;
  localparam logic [2:0] PRE_LAST_RESET = 3'd5;
  // RTI -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR.
  localparam logic [7:0] TMS_PRE_IR = 8'b0000_0011;
  localparam logic [2:0] PRE_LAST_IR = 3'd3;
  // RTI -> Select-DR -> Capture-DR -> Shift-DR.
  localparam logic [7:0] TMS_PRE_DR = 8'b0000_0001;
  localparam logic [2:0] PRE_LAST_DR = 3'd2;
  // Exit1 -> Update -> RTI (the Exit1 step is the last SHIFT period).
  localparam logic [7:0] TMS_POST = 8'b0000_0001;
  localparam logic [2:0] POST_LAST = 3'd1;

  function automatic logic [7:0] pre_pattern(input op_t op);
    case (op)
      OP_RESET:   return TMS_PRE_RESET;
      OP_SCAN_IR: return TMS_PRE_IR;
      OP_SCAN_DR: return TMS_PRE_DR;
      default:    return 8'h00;
    endcase
  endfunction

  // Index of the last PRE period for an op.
  function automatic logic [2:0] pre_last(input op_t op);
    case (op)
      OP_RESET:   return PRE_LAST_RESET;
      OP_SCAN_IR: return PRE_LAST_IR;
      OP_SCAN_DR: return PRE_LAST_DR;
      default:    return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/jtag_shift_master_if.sv
// ---------------------------------------------------------------------------
// jtag_shift_master_if
// Host command/response bundle of the JTAG shift master.
//   cmd_valid/cmd_ready  command handshake
//   cmd_op, cmd_len, cmd_data  command fields (data shifted LSB first)
//   rsp_valid  one-cycle completion pulse
//   rsp_err, rsp_data  result, held until the next completion
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
// the host keeps fields stable while cmd_valid is high and unaccepted.
// rsp_valid is a pulse with no back-pressure.
// ---------------------------------------------------------------------------
interface jtag_shift_master_if #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_err;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_err, rsp_data
  );
endinterface

// File: rtl/jtag_tck_gen.sv
// ---------------------------------------------------------------------------
// jtag_tck_gen
// TCK divider. While i_en is high each TCK period is TCK_DIV clk cycles low
// followed by TCK_DIV cycles high; while i_en is low the counter is cleared
// and TCK is held low.
//   clk, rst_n      system clock, async active-low reset
//   i_en            run the divider
//   o_tck           registered TCK
//   o_rise_strobe   high in the clk cycle whose closing edge raises TCK
//   o_fall_strobe   high in the clk cycle whose closing edge drops TCK,
//                   i.e. the edge that starts the next low phase
// ---------------------------------------------------------------------------
module jtag_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tck,
  output logic o_rise_strobe,
  output logic o_fall_strobe
);

  localparam int CNT_W = $clog2(2 * TCK_DIV);
  localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] FALL_AT = CNT_W'(2 * TCK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tck;

  assign o_rise_strobe = i_en && (r_cnt == RISE_AT);
  assign o_fall_strobe = i_en && (r_cnt == FALL_AT);
  assign o_tck         = r_tck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (o_fall_strobe) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_rise_strobe) r_tck <= 1'b1;
    end
  end

endmodule

// File: rtl/jtag_shift_master.sv
// ---------------------------------------------------------------------------
// jtag_shift_master
// JTAG initiator: walks the TAP controller through IR/DR scans, reset and
// idle cycles on behalf of a host, and always leaves it in Run-Test/Idle.
//   clk, rst_n     system clock, async active-low reset
//   host           command/response port (jtag_shift_master_if.slave)
//   jtag_tck/tms/tdi  TAP pins driven by this block
//   jtag_tdo       TAP data out, sampled in the cycle TCK rises
//   o_dbg_state    current sequencer state
// Sequencer: IDLE -> PRE (TMS walk) -> SHIFT (len periods) -> POST (exit
// to RTI) -> DONE (rsp_valid pulse) -> IDLE. RESET uses only PRE, IDLE_CYC
// only SHIFT, and a bad length jumps straight from IDLE to DONE.
// TMS/TDI are decoded from registered state that only advances at TCK
// falling edges, so they change together with the falling edge.
// ---------------------------------------------------------------------------
module jtag_shift_master
  import jtag_pkg::*;
#(
  parameter int TCK_DIV = 4,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic   clk,
  input  logic   rst_n,
  jtag_shift_master_if.slave host,
  output logic   jtag_tck,
  output logic   jtag_tms,
  output logic   jtag_tdi,
  input  logic   jtag_tdo,
  output state_t o_dbg_state
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             r_state;
  state_t             w_next;
  op_t                r_op;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;      // period index within the current phase
  logic [MAX_LEN-1:0] r_tx;       // TDI bits, consumed from bit 0
  logic [MAX_LEN-1:0] r_cap;      // TDO bits, entering at the top
  logic [MAX_LEN-1:0] r_rsp_data;
  logic               r_rsp_err;

  logic               w_accept;
  logic               w_len_bad;
  logic               w_is_scan;
  logic               w_last_shift;
  logic               w_busy;
  logic               w_rise;
  logic               w_fall;
  logic               w_tck;
  logic [7:0]         w_pre_sh;
  logic [7:0]         w_post_sh;
  logic [LEN_W-1:0]   w_shamt;
  logic               w_tms;
  logic               w_tdi;

  assign w_accept     = host.cmd_valid && (r_state == ST_IDLE);
  assign w_len_bad    = (op_t'(host.cmd_op) != OP_RESET) &&
                        ((host.cmd_len == '0) || (host.cmd_len > MAX_LEN_L));
  assign w_is_scan    = (r_op == OP_SCAN_IR) || (r_op == OP_SCAN_DR);
  assign w_last_shift = (r_cnt == (r_len - LEN_W'(1)));
  assign w_busy       = (r_state == ST_PRE) || (r_state == ST_SHIFT) ||
                        (r_state == ST_POST);
  assign w_pre_sh     = pre_pattern(r_op) >> r_cnt;
  assign w_post_sh    = TMS_POST >> r_cnt;
  // Captured bits sit in the top r_len positions; realign so bit 0 is first.
  assign w_shamt      = MAX_LEN_L - r_len;

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (w_busy),
    .o_tck         (w_tck),
    .o_rise_strobe (w_rise),
    .o_fall_strobe (w_fall)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and pin decode.
  always_comb begin
    w_next = r_state;
    w_tms  = 1'b1;
    w_tdi  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_len_bad)                                   w_next = ST_DONE;
          else if (op_t'(host.cmd_op) == OP_IDLE_CYC)      w_next = ST_SHIFT;
          else                                             w_next = ST_PRE;
        end
      end
      ST_PRE: begin
        w_tms = w_pre_sh[0];
        if (w_fall && (r_cnt == LEN_W'(pre_last(r_op))))
          w_next = (r_op == OP_RESET) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_is_scan) begin
          w_tms = w_last_shift;
          w_tdi = r_tx[0];
        end else begin
          w_tms = 1'b0;
        end
        if (w_fall && w_last_shift)
          w_next = w_is_scan ? ST_POST : ST_DONE;
      end
      ST_POST: begin
        w_tms = w_post_sh[0];
        if (w_fall && (r_cnt == LEN_W'(POST_LAST))) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_tms  = 1'b0;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= OP_RESET;
      r_len      <= '0;
      r_cnt      <= '0;
      r_tx       <= '0;
      r_cap      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= op_t'(host.cmd_op);
        r_len <= host.cmd_len;
        r_tx  <= host.cmd_data;
        r_cap <= '0;
      end

      if (w_next != r_state) r_cnt <= '0;
      else if (w_fall)       r_cnt <= r_cnt + LEN_W'(1);

      if ((r_state == ST_SHIFT) && w_fall) r_tx <= r_tx >> 1;

      if ((r_state == ST_SHIFT) && w_rise && w_is_scan)
        r_cap <= {jtag_tdo, r_cap[MAX_LEN-1:1]};

      if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
        if (r_state == ST_IDLE) begin
          r_rsp_err  <= 1'b1;
          r_rsp_data <= '0;
        end else begin
          r_rsp_err  <= 1'b0;
          r_rsp_data <= w_is_scan ? (r_cap >> w_shamt) : '0;
        end
      end
    end
  end

  assign host.cmd_ready = (r_state == ST_IDLE);
  assign host.rsp_valid = (r_state == ST_DONE);
  assign host.rsp_err   = r_rsp_err;
  assign host.rsp_data  = r_rsp_data;
  assign jtag_tck       = w_tck;
  assign jtag_tms       = w_tms;
  assign jtag_tdi       = w_tdi;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_jtag_shift_master.sv
// ---------------------------------------------------------------------------
// tb_jtag_shift_master
// Drives host commands against a pin-level TAP model (IR 5 bits, IDCODE,
// 64-bit USER register, BYPASS) and checks every response against a
// command-level reference model through an expected-response queue.
// ---------------------------------------------------------------------------
module tb_jtag_shift_master;
  import jtag_pkg::*;

  localparam int TCK_DIV = 4;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
  localparam logic [31:0] IDCODE_VAL = 32'h1E20_0A6D;
  localparam logic [4:0]  IR_IDCODE  = 5'h01;
  localparam logic [4:0]  IR_USER    = 5'h02;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   jtag_tck, jtag_tms, jtag_tdi;
  logic   jtag_tdo = 1'b0;
  state_t dbg_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jtag_shift_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) host ();

  jtag_shift_master #(.TCK_DIV(TCK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (host),
    .jtag_tck    (jtag_tck),
    .jtag_tms    (jtag_tms),
    .jtag_tdi    (jtag_tdi),
    .jtag_tdo    (jtag_tdo),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- pin-level TAP model ----------------
  typedef enum int {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_t;

  tap_t        tap = TLR;
  logic [4:0]  tap_ir = IR_IDCODE;
  logic [4:0]  tap_ir_sr = 5'h0;
  logic [63:0] tap_dr_sr = 64'h0;
  logic [63:0] tap_user = 64'h0;
  int          tap_dr_len = 1;
  int          n_rise = 0;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PA_DR;
      PA_DR:   return tms ? EX2_DR : PA_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PA_IR;
      PA_IR:   return tms ? EX2_IR : PA_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      UPD_IR:  return tms ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge jtag_tck) begin
    n_rise++;
    case (tap)
      TLR:    tap_ir = IR_IDCODE;
      CAP_IR: tap_ir_sr = 5'b00001;
      SH_IR:  tap_ir_sr = {jtag_tdi, tap_ir_sr[4:1]};
      UPD_IR: tap_ir = tap_ir_sr;
      CAP_DR: begin
        if (tap_ir == IR_IDCODE) begin
          tap_dr_len = 32; tap_dr_sr = {32'h0, IDCODE_VAL};
        end else if (tap_ir == IR_USER) begin
          tap_dr_len = 64; tap_dr_sr = tap_user;
        end else begin
          tap_dr_len = 1;  tap_dr_sr = 64'h0;
        end
      end
      SH_DR: begin
        tap_dr_sr = tap_dr_sr >> 1;
        tap_dr_sr[tap_dr_len-1] = jtag_tdi;
      end
      UPD_DR: if (tap_ir == IR_USER) tap_user = tap_dr_sr;
      default: ;
    endcase
    tap = tap_next(tap, jtag_tms);
  end

  always @(negedge jtag_tck) begin
    if (tap == SH_IR)      jtag_tdo = tap_ir_sr[0];
    else if (tap == SH_DR) jtag_tdo = tap_dr_sr[0];
    else                   jtag_tdo = 1'b0;
  end

  // ---------------- command-level reference model ----------------
  logic [4:0]  ref_ir = IR_IDCODE;
  logic [63:0] ref_user = 64'h0;

  task automatic ref_cmd(input op_t op, input int len, input logic [63:0] din,
                         output logic err, output logic [63:0] dout, output int periods);
    logic        chain[$];
    logic [63:0] cap;
    int          clen;
    err = 1'b0; dout = 64'h0; periods = 0; cap = 64'h0; clen = 0;
    if (op != OP_RESET && (len == 0 || len > MAX_LEN)) begin
      err = 1'b1;
      return;
    end
    case (op)
      OP_RESET:    begin ref_ir = IR_IDCODE; periods = 6; end
      OP_IDLE_CYC: periods = len;
      OP_SCAN_IR:  begin periods = 6 + len; clen = 5; cap = 64'h1; end
      default: begin
        periods = 5 + len;
        if (ref_ir == IR_IDCODE)    begin clen = 32; cap = {32'h0, IDCODE_VAL}; end
        else if (ref_ir == IR_USER) begin clen = 64; cap = ref_user; end
        else                        begin clen = 1;  cap = 64'h0; end
      end
    endcase
    if (op == OP_SCAN_IR || op == OP_SCAN_DR) begin
      for (int k = 0; k < clen; k++) chain.push_back(cap[k]);
      for (int i = 0; i < len; i++) begin
        dout[i] = chain.pop_front();
        chain.push_back(din[i]);
      end
      if (op == OP_SCAN_IR)
        for (int k = 0; k < 5; k++) ref_ir[k] = chain[k];
      else if (ref_ir == IR_USER)
        for (int k = 0; k < 64; k++) ref_user[k] = chain[k];
    end
  endtask

  // ---------------- scoreboard queues ----------------
  logic [63:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_per_q[$];
  int          acc_q[$];
  int          rise_base = 0;

  // ---------------- driver ----------------
  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!host.cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!host.cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout: got 0, expected 1");
    end
  endtask

  task automatic send(input op_t op, input int len, input logic [63:0] din);
    logic        err;
    logic [63:0] dout;
    int          per;
    wait_ready();
    ref_cmd(op, len, din, err, dout, per);
    exp_q.push_back(dout);
    exp_err_q.push_back(err);
    exp_per_q.push_back(per);
    acc_q.push_back(cyc + 1);
    host.cmd_valid = 1'b1;
    host.cmd_op    = op;
    host.cmd_len   = LEN_W'(len);
    host.cmd_data  = din;
    @(negedge clk);
    host.cmd_valid = 1'b0;
    host.cmd_data  = {$urandom, $urandom};
  endtask

  // ---------------- monitor ----------------
  logic        post_chk = 1'b0;
  logic [63:0] last_data = 64'h0;
  logic [63:0] m_d;
  logic        m_e;
  int          m_p, m_a;

  always @(negedge clk) begin
    if (rst_n) begin
      if (post_chk) begin
        post_chk = 1'b0;
        check("ready_after_rsp", host.cmd_ready, 1);
        check("rsp_single_pulse", host.rsp_valid, 0);
        check("rsp_data_hold", host.rsp_data, last_data);
      end
      if (host.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
        end else begin
          m_d = exp_q.pop_front();
          m_e = exp_err_q.pop_front();
          m_p = exp_per_q.pop_front();
          m_a = acc_q.pop_front();
          check("rsp_err", host.rsp_err, m_e);
          check("rsp_data", host.rsp_data, m_d);
          check("tck_periods", n_rise - rise_base, m_p);
          check("latency", cyc - m_a, m_e ? 0 : m_p * 2 * TCK_DIV);
          check("tap_in_rti", tap == RTI, 1);
          check("ready_low_in_done", host.cmd_ready, 0);
          last_data = host.rsp_data;
        end
        rise_base = n_rise;
        post_chk  = 1'b1;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900_000;
    $display("FAIL watchdog: got no completion, expected end of stimulus");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int          r, len, guard;
    op_t         op;
    logic [63:0] d;
    logic [4:0]  irv;

    host.cmd_valid = 1'b0;
    host.cmd_op    = 2'b00;
    host.cmd_len   = '0;
    host.cmd_data  = '0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", host.cmd_ready, 1);
    check("rst_rsp_valid", host.rsp_valid, 0);
    check("rst_rsp_err", host.rsp_err, 0);
    check("rst_rsp_data", host.rsp_data, 0);
    check("rst_tck", jtag_tck, 0);
    check("rst_tms", jtag_tms, 1);
    check("rst_tdi", jtag_tdi, 0);
    rst_n = 1'b1;

    // Directed scans.
    send(OP_RESET, 0, 64'h0);
    send(OP_SCAN_IR, 5, 64'h01);
    send(OP_SCAN_DR, 32, 64'h0);
    send(OP_SCAN_IR, 5, {59'h0, IR_USER});
    send(OP_SCAN_DR, 64, 64'hA5A5_0000_FFFF_1234);
    send(OP_SCAN_DR, 64, 64'h0);
    send(OP_SCAN_DR, 0, 64'hFFFF);
    send(OP_SCAN_DR, 65, 64'hFFFF);
    send(OP_SCAN_IR, 127, 64'h1F);
    send(OP_IDLE_CYC, 0, 64'h0);
    send(OP_IDLE_CYC, 10, 64'hFFFF_FFFF_FFFF_FFFF);
    send(OP_RESET, 100, 64'h0);

    // Reset in the middle of a DR shift (IR is IDCODE, so no update side effect).
    wait_ready();
    host.cmd_valid = 1'b1;
    host.cmd_op    = OP_SCAN_DR;
    host.cmd_len   = LEN_W'(64);
    host.cmd_data  = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    host.cmd_valid = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check("abort_in_shift", dbg_state, ST_SHIFT);
    rst_n = 1'b0;
    #1;
    check("abort_tck", jtag_tck, 0);
    check("abort_tms", jtag_tms, 1);
    check("abort_tdi", jtag_tdi, 0);
    check("abort_cmd_ready", host.cmd_ready, 1);
    check("abort_rsp_valid", host.rsp_valid, 0);
    rise_base = n_rise;
    @(negedge clk);
    rst_n = 1'b1;
    send(OP_RESET, 0, 64'h0);
    send(OP_SCAN_IR, 5, 64'h01);
    send(OP_SCAN_DR, 32, 64'h0);

    // Randomized mix.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      d = {$urandom, $urandom};
      case (r)
        0: send(OP_RESET, $urandom_range(0, 127), d);
        1, 2, 3: begin
          case ($urandom_range(0, 3))
            0: irv = IR_IDCODE;
            1: irv = IR_USER;
            2: irv = 5'h1F;
            default: irv = 5'($urandom);
          endcase
          d[4:0] = irv;
          len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 5;
          send(OP_SCAN_IR, len, d);
        end
        4, 5, 6, 7: send(OP_SCAN_DR, $urandom_range(1, 64), d);
        8: send(OP_IDLE_CYC, $urandom_range(1, 20), d);
        default: begin
          len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(65, 127);
          op  = op_t'(2'($urandom_range(1, 3)));
          send(op, len, d);
        end
      endcase
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("all_rsp_seen", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
